data_sram_responder: RTL and testbench

Memory-side responder for the CPU's data SRAM port: accepts the `data_sram_*` requests the core issues from its MEM stage and returns `data_sram_rdata` one cycle later, as the core's WB stage expects. It routes each request either to an internal word RAM with byte write enables or to a small MMIO register bank. The MMIO bank holds LEDs, switches, a free-running timer with compare, and an interrupt status/enable pair. The interrupt output feeds one bit of the core's `ext_int`.

---
 rtl/mmio_pkg.sv | 28 ++
 rtl/data_sram_responder_if.sv | 27 ++
 rtl/mmio_regs.sv | 95 +++++++++
 rtl/data_sram_responder.sv | 86 ++++++++
 tb/tb_data_sram_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the data SRAM responder: MMIO window base, register
// offsets within the window, and the byte-lane merge helper.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

    localparam logic [7:0] MMIO_LED        = 8'h00;
    localparam logic [7:0] MMIO_SWITCH     = 8'h04;
    localparam logic [7:0] MMIO_TIMER      = 8'h08;
    localparam logic [7:0] MMIO_COMPARE    = 8'h0C;
    localparam logic [7:0] MMIO_INT_STATUS = 8'h10;
    localparam logic [7:0] MMIO_INT_ENABLE = 8'h14;

    // Replace each byte of old_word whose enable bit is set with the matching lane of new_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data SRAM port between the core's MEM stage (master) and the memory-side
// responder (slave).
interface data_sram_responder_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

// File: rtl/mmio_regs.sv
// MMIO register bank: LEDs, synchronized switches, free-running timer with
// compare, and the timer interrupt status/enable pair.
module mmio_regs
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  offset,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    input  logic [15:0] switch_in,
    output logic [31:0] rdata,
    output logic [15:0] led_out,
    output logic        timer_irq
);

    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] compare_q, compare_d;
    logic        int_status_q, int_status_d;
    logic        int_enable_q, int_enable_d;
    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;

    always_comb begin
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        compare_d    = compare_q;
        int_status_d = int_status_q;
        int_enable_d = int_enable_q;
        sync1_d      = switch_in;
        sync2_d      = sync1_q;

        if (wr_en) begin
            case (offset)
                MMIO_LED: begin
                    if (wen[0]) led_d[7:0]  = wdata[7:0];
                    if (wen[1]) led_d[15:8] = wdata[15:8];
                end
                MMIO_TIMER:      timer_d   = byte_merge(timer_q, wdata, wen);
                MMIO_COMPARE:    compare_d = byte_merge(compare_q, wdata, wen);
                MMIO_INT_STATUS: begin
                    if (wen[0] && wdata[0]) int_status_d = 1'b0;
                end
                MMIO_INT_ENABLE: begin
                    if (wen[0]) int_enable_d = wdata[0];
                end
                default: ;
            endcase
        end

        // A match overrides a same-cycle W1C so no timer event is ever lost.
        if (timer_q == compare_q) begin
            int_status_d = 1'b1;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (offset)
            MMIO_LED:        rdata = {16'h0, led_q};
            MMIO_SWITCH:     rdata = {16'h0, sync2_q};
            MMIO_TIMER:      rdata = timer_q;
            MMIO_COMPARE:    rdata = compare_q;
            MMIO_INT_STATUS: rdata = {31'h0, int_status_q};
            MMIO_INT_ENABLE: rdata = {31'h0, int_enable_q};
            default:         rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q        <= 16'h0;
            timer_q      <= 32'h0;
            compare_q    <= 32'hFFFF_FFFF;
            int_status_q <= 1'b0;
            int_enable_q <= 1'b0;
            sync1_q      <= 16'h0;
            sync2_q      <= 16'h0;
        end else begin
            led_q        <= led_d;
            timer_q      <= timer_d;
            compare_q    <= compare_d;
            int_status_q <= int_status_d;
            int_enable_q <= int_enable_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
        end
    end

    assign led_out   = led_q;
    assign timer_irq = int_status_q & int_enable_q;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the core's data SRAM port: decodes each request to
// the internal word RAM or the MMIO bank and returns read data one cycle later.
module data_sram_responder
    import mmio_pkg::*;
#(
    parameter int          RAM_ADDR_W = 12,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_responder_if.slave  bus,
    input  logic [15:0]           switch_in,
    output logic [15:0]           led_out,
    output logic                  timer_irq
);

    localparam int RAM_WORDS = 1 << RAM_ADDR_W;

    logic [31:0]           ram [RAM_WORDS];
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  mmio_hit;
    logic                  mmio_wr_en;
    logic [31:0]           mmio_rdata;
    logic [31:0]           ram_rdata_q;
    logic                  sel_mmio_q, sel_mmio_d;
    logic [31:0]           mmio_rdata_q, mmio_rdata_d;
    logic                  unused_addr_bits;

    assign mmio_hit   = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign ram_idx    = bus.data_sram_addr[RAM_ADDR_W+1:2];
    assign mmio_wr_en = bus.data_sram_en && mmio_hit && (bus.data_sram_wen != 4'h0);

    // Byte offset bits and the aliased upper RAM address bits are ignored by design.
    assign unused_addr_bits = ^bus.data_sram_addr;

    mmio_regs u_mmio_regs (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (mmio_wr_en),
        .offset    (bus.data_sram_addr[7:0]),
        .wen       (bus.data_sram_wen),
        .wdata     (bus.data_sram_wdata),
        .switch_in (switch_in),
        .rdata     (mmio_rdata),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    // RAM port kept in one block so it maps onto a read-before-write block RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rdata_q <= 32'h0;
        end else if (bus.data_sram_en && !mmio_hit) begin
            ram_rdata_q <= ram[ram_idx];
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    ram[ram_idx][i*8 +: 8] <= bus.data_sram_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        sel_mmio_d   = sel_mmio_q;
        mmio_rdata_d = mmio_rdata_q;
        if (bus.data_sram_en) begin
            sel_mmio_d = mmio_hit;
            if (mmio_hit) begin
                mmio_rdata_d = mmio_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_mmio_q   <= 1'b0;
            mmio_rdata_q <= 32'h0;
        end else begin
            sel_mmio_q   <= sel_mmio_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign bus.data_sram_rdata = sel_mmio_q ? mmio_rdata_q : ram_rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed requests with literal
// expectations plus a transaction-level model compared every cycle.
module tb_data_sram_responder;

    localparam logic [31:0] BASE        = 32'hBFAF_0000;
    localparam logic [31:0] A_LED       = BASE + 32'h00;
    localparam logic [31:0] A_SWITCH    = BASE + 32'h04;
    localparam logic [31:0] A_TIMER     = BASE + 32'h08;
    localparam logic [31:0] A_COMPARE   = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS    = BASE + 32'h10;
    localparam logic [31:0] A_ENABLE    = BASE + 32'h14;
    localparam logic [31:0] A_UNMAPPED  = BASE + 32'hF0;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    data_sram_responder_if bus ();

    data_sram_responder #(
        .RAM_ADDR_W (12),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drives one request for one full cycle; returns at the following falling edge.
    task automatic applyStimulus(input logic en, input logic [3:0] wen,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
        applyStimulus(1'b1, wen, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        applyStimulus(1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Transaction-level model: memory as a sparse word map, registers as plain variables.
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_timer, m_compare, m_rdata;
    bit          m_status, m_enable, m_known, m_ready = 1'b0;
    logic [15:0] m_sync1, m_sync2;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (wen[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_mmio_read(input logic [7:0] off);
        case (off)
            8'h00:   return {16'h0, m_led};
            8'h04:   return {16'h0, m_sync2};
            8'h08:   return m_timer;
            8'h0C:   return m_compare;
            8'h10:   return {31'h0, m_status};
            8'h14:   return {31'h0, m_enable};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] next_timer, tmp, addr, wdata;
        logic [3:0]  wen;
        int          idx;
        bit          match;
        addr  = bus.data_sram_addr;
        wen   = bus.data_sram_wen;
        wdata = bus.data_sram_wdata;
        if (reset) begin
            m_rdata = 32'h0; m_known = 1'b1; m_led = 16'h0; m_timer = 32'h0;
            m_compare = 32'hFFFF_FFFF; m_status = 1'b0; m_enable = 1'b0;
            m_sync1 = 16'h0; m_sync2 = 16'h0; m_ready = 1'b1;
        end else if (m_ready) begin
            match      = (m_timer == m_compare);
            next_timer = m_timer + 32'd1;
            if (bus.data_sram_en) begin
                if (addr[31:16] == 16'hBFAF) begin
                    m_rdata = model_mmio_read(addr[7:0]);
                    m_known = 1'b1;
                    if (wen != 4'h0) begin
                        case (addr[7:0])
                            8'h00: begin tmp = merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
                            8'h08: next_timer = merge(m_timer, wdata, wen);
                            8'h0C: m_compare = merge(m_compare, wdata, wen);
                            8'h10: if (wen[0] && wdata[0]) m_status = 1'b0;
                            8'h14: if (wen[0]) m_enable = wdata[0];
                            default: ;
                        endcase
                    end
                end else begin
                    idx = int'(addr[13:2]);
                    m_known = m_mem.exists(idx);
                    if (m_known) m_rdata = m_mem[idx];
                    if (wen != 4'h0) m_mem[idx] = merge(m_known ? m_mem[idx] : 32'h0, wdata, wen);
                end
            end
            if (match) m_status = 1'b1;
            m_timer = next_timer;
            m_sync2 = m_sync1;
            m_sync1 = switch_in;
        end
        #1;
        if (m_ready) begin
            checkOutput("model_led", {16'h0, led_out}, {16'h0, m_led});
            checkOutput("model_irq", {31'h0, timer_irq}, {31'h0, m_status & m_enable});
            if (m_known) checkOutput("model_rdata", bus.data_sram_rdata, m_rdata);
        end
    end

    initial begin
        reset = 1'b1;
        switch_in = 16'h0;
        bus.data_sram_en = 1'b0; bus.data_sram_wen = 4'h0;
        bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rdata", bus.data_sram_rdata, 32'h0);
        checkOutput("reset_led", {16'h0, led_out}, 32'h0);
        checkOutput("reset_irq", {31'h0, timer_irq}, 32'h0);
        reset = 1'b0;

        // RAM byte lanes, read-before-write, pipelining, aliasing, hold
        wr(32'h10, 4'hF, 32'hDDCC_BBAA);
        wr(32'h10, 4'b0010, 32'h0000_5500);
        rd(32'h10);
        checkOutput("ram_byte_write", bus.data_sram_rdata, 32'hDDCC_55AA);
        wr(32'h20, 4'hF, 32'hCAFE_F00D);
        wr(32'h20, 4'hF, 32'h1234_5678);
        checkOutput("ram_rbw_old", bus.data_sram_rdata, 32'hCAFE_F00D);
        rd(32'h20);
        checkOutput("ram_rbw_new", bus.data_sram_rdata, 32'h1234_5678);
        rd(32'h10);
        checkOutput("ram_pipe0", bus.data_sram_rdata, 32'hDDCC_55AA);
        rd(32'h20);
        checkOutput("ram_pipe1", bus.data_sram_rdata, 32'h1234_5678);
        idle();
        checkOutput("rdata_hold", bus.data_sram_rdata, 32'h1234_5678);
        rd(32'h0000_4010);
        checkOutput("ram_alias", bus.data_sram_rdata, 32'hDDCC_55AA);

        // LED and SWITCH
        wr(A_LED, 4'hF, 32'hFFFF_A5A5);
        checkOutput("led_out", {16'h0, led_out}, 32'h0000_A5A5);
        rd(A_LED);
        checkOutput("led_readback", bus.data_sram_rdata, 32'h0000_A5A5);
        wr(A_LED, 4'b0001, 32'h0000_003C);
        checkOutput("led_byte_en", {16'h0, led_out}, 32'h0000_A53C);
        switch_in = 16'h00F0;
        idle();
        rd(A_SWITCH);
        checkOutput("switch_early", bus.data_sram_rdata, 32'h0);
        rd(A_SWITCH);
        checkOutput("switch_sync", bus.data_sram_rdata, 32'h0000_00F0);

        // Timer match, interrupt rise, W1C, and W1C losing to a same-cycle match
        wr(A_TIMER, 4'hF, 32'h0);
        wr(A_COMPARE, 4'hF, 32'h5);
        wr(A_ENABLE, 4'h1, 32'h1);
        for (int c = 3; c <= 7; c++) begin
            checkOutput($sformatf("irq_rise_c%0d", c), {31'h0, timer_irq}, (c == 7) ? 32'h1 : 32'h0);
            if (c < 7) idle();
        end
        wr(A_STATUS, 4'h1, 32'h1);
        checkOutput("irq_w1c_drop", {31'h0, timer_irq}, 32'h0);
        wr(A_COMPARE, 4'hF, 32'd20);
        repeat (12) idle();
        wr(A_STATUS, 4'h1, 32'h1);
        checkOutput("irq_w1c_vs_match", {31'h0, timer_irq}, 32'h1);
        wr(A_STATUS, 4'h1, 32'h1);
        checkOutput("irq_cleared", {31'h0, timer_irq}, 32'h0);

        // Timer wrap and write priority over increment
        wr(A_TIMER, 4'hF, 32'hFFFF_FFFF);
        idle();
        rd(A_TIMER);
        checkOutput("timer_wrap", bus.data_sram_rdata, 32'h0);
        wr(A_TIMER, 4'hF, 32'h0000_0100);
        rd(A_TIMER);
        checkOutput("timer_write_prio", bus.data_sram_rdata, 32'h0000_0100);
        wr(A_TIMER, 4'b0001, 32'h0000_00AB);
        idle();

        // Reset in the middle of a RAM write
        wr(32'h30, 4'hF, 32'h0BAD_BEEF);
        reset = 1'b1;
        wr(32'h30, 4'hF, 32'hFFFF_FFFF);
        reset = 1'b0;
        checkOutput("reset_drop_rdata", bus.data_sram_rdata, 32'h0);
        checkOutput("reset_led_mid", {16'h0, led_out}, 32'h0);
        rd(A_TIMER);
        checkOutput("reset_timer", bus.data_sram_rdata, 32'h0);
        rd(32'h30);
        checkOutput("reset_no_ram_write", bus.data_sram_rdata, 32'h0BAD_BEEF);
        rd(A_UNMAPPED);
        checkOutput("unmapped_read", bus.data_sram_rdata, 32'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
